// File: rtl/fmul_72bit_norm.sv
// Final normalise/round/pack stage of the 72-bit floating-point multiplier.
// Two registered stages behind a shared valid/busy handshake (latency 2).
module fmul_72bit_norm #(
  parameter int          P_ROUND_MODE = 0,
  parameter logic [59:0] P_QNAN_FRACT = 60'h800000000000000
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iRESET_SYNC,
  input  logic         iDATA_REQ,
  output logic         oDATA_BUSY,
  input  logic         iDATA_SIGN,
  input  logic [12:0]  iDATA_EXP,
  input  logic [119:0] iDATA_FRACT,
  input  logic         iDATA_EXCEPT_EXP_A0,
  input  logic         iDATA_EXCEPT_EXP_B0,
  input  logic         iDATA_EXCEPT_EXP_A1,
  input  logic         iDATA_EXCEPT_EXP_B1,
  input  logic         iDATA_EXCEPT_FRACT_A0,
  input  logic         iDATA_EXCEPT_FRACT_B0,
  output logic         oDATA_VALID,
  input  logic         iDATA_BUSY,
  output logic [71:0]  oDATA_RESULT,
  output logic         oDATA_FLAG_INVALID,
  output logic         oDATA_FLAG_OVERFLOW,
  output logic         oDATA_FLAG_UNDERFLOW,
  output logic         oDATA_FLAG_INEXACT
);

  assign oDATA_BUSY = iDATA_BUSY;

  logic        norm_shift;
  logic [59:0] norm_mant;
  logic        norm_guard;
  logic        norm_sticky;
  logic [13:0] norm_exp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        cls_nan, cls_inf, cls_zero;

  always_comb begin
    norm_shift  = iDATA_FRACT[119];
    norm_mant   = norm_shift ? iDATA_FRACT[118:59] : iDATA_FRACT[117:58];
    norm_guard  = norm_shift ? iDATA_FRACT[58] : iDATA_FRACT[57];
    norm_sticky = norm_shift ? (|iDATA_FRACT[57:0]) : (|iDATA_FRACT[56:0]);
    norm_exp    = {iDATA_EXP[12], iDATA_EXP} + {13'b0, norm_shift};
    a_zero      = iDATA_EXCEPT_EXP_A0;
    b_zero      = iDATA_EXCEPT_EXP_B0;
    a_inf       = iDATA_EXCEPT_EXP_A1 && iDATA_EXCEPT_FRACT_A0;
    b_inf       = iDATA_EXCEPT_EXP_B1 && iDATA_EXCEPT_FRACT_B0;
    a_nan       = iDATA_EXCEPT_EXP_A1 && !iDATA_EXCEPT_FRACT_A0;
    b_nan       = iDATA_EXCEPT_EXP_B1 && !iDATA_EXCEPT_FRACT_B0;
    // Class priority is resolved early so stage 1 only carries three bits.
    cls_nan     = a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero));
    cls_inf     = a_inf || b_inf;
    cls_zero    = a_zero || b_zero;
  end

  logic        st0_valid;
  logic        st0_sign;
  logic [59:0] st0_mant;
  logic        st0_guard;
  logic        st0_sticky;
  logic [13:0] st0_exp;
  logic        st0_nan, st0_inf, st0_zero;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      st0_valid  <= 1'b0;
      st0_sign   <= 1'b0;
      st0_mant   <= '0;
      st0_guard  <= 1'b0;
      st0_sticky <= 1'b0;
      st0_exp    <= '0;
      st0_nan    <= 1'b0;
      st0_inf    <= 1'b0;
      st0_zero   <= 1'b0;
    end else if (iRESET_SYNC) begin
      st0_valid  <= 1'b0;
      st0_sign   <= 1'b0;
      st0_mant   <= '0;
      st0_guard  <= 1'b0;
      st0_sticky <= 1'b0;
      st0_exp    <= '0;
      st0_nan    <= 1'b0;
      st0_inf    <= 1'b0;
      st0_zero   <= 1'b0;
    end else if (!iDATA_BUSY) begin
      st0_valid  <= iDATA_REQ;
      st0_sign   <= iDATA_SIGN;
      st0_mant   <= norm_mant;
      st0_guard  <= norm_guard;
      st0_sticky <= norm_sticky;
      st0_exp    <= norm_exp;
      st0_nan    <= cls_nan;
      st0_inf    <= cls_inf;
      st0_zero   <= cls_zero;
    end
  end

  logic        round_up;
  logic [60:0] round_mant;
  logic [13:0] round_exp;
  logic [71:0] result_n;
  logic        invalid_n, overflow_n, underflow_n, inexact_n;

  always_comb begin
    round_up    = (P_ROUND_MODE == 0) ? (st0_guard & (st0_sticky | st0_mant[0])) : 1'b0;
    // A carry out only happens from all-ones, leaving the low 60 bits zero.
    round_mant  = {1'b0, st0_mant} + {60'b0, round_up};
    round_exp   = st0_exp + {13'b0, round_mant[60]};
    result_n    = {st0_sign, round_exp[10:0], round_mant[59:0]};
    invalid_n   = 1'b0;
    overflow_n  = 1'b0;
    underflow_n = 1'b0;
    inexact_n   = 1'b0;
    if (st0_nan) begin
      result_n  = {1'b0, 11'h7FF, P_QNAN_FRACT};
      invalid_n = 1'b1;
    end else if (st0_inf) begin
      result_n  = {st0_sign, 11'h7FF, 60'b0};
    end else if (st0_zero) begin
      result_n  = {st0_sign, 11'h000, 60'b0};
    end else if ($signed(round_exp) >= 14'sd2047) begin
      result_n   = {st0_sign, 11'h7FF, 60'b0};
      overflow_n = 1'b1;
      inexact_n  = 1'b1;
    end else if ($signed(round_exp) <= 14'sd0) begin
      result_n    = {st0_sign, 11'h000, 60'b0};
      underflow_n = 1'b1;
      inexact_n   = 1'b1;
    end else begin
      inexact_n = st0_guard | st0_sticky;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      oDATA_VALID          <= 1'b0;
      oDATA_RESULT         <= '0;
      oDATA_FLAG_INVALID   <= 1'b0;
      oDATA_FLAG_OVERFLOW  <= 1'b0;
      oDATA_FLAG_UNDERFLOW <= 1'b0;
      oDATA_FLAG_INEXACT   <= 1'b0;
    end else if (iRESET_SYNC) begin
      oDATA_VALID          <= 1'b0;
      oDATA_RESULT         <= '0;
      oDATA_FLAG_INVALID   <= 1'b0;
      oDATA_FLAG_OVERFLOW  <= 1'b0;
      oDATA_FLAG_UNDERFLOW <= 1'b0;
      oDATA_FLAG_INEXACT   <= 1'b0;
    end else if (!iDATA_BUSY) begin
      oDATA_VALID          <= st0_valid;
      oDATA_RESULT         <= result_n;
      oDATA_FLAG_INVALID   <= invalid_n;
      oDATA_FLAG_OVERFLOW  <= overflow_n;
      oDATA_FLAG_UNDERFLOW <= underflow_n;
      oDATA_FLAG_INEXACT   <= inexact_n;
    end
  end

endmodule

// File: tb/tb_fmul_72bit_norm.sv
// Scoreboard bench for fmul_72bit_norm: directed vectors push expected
// {result, invalid, overflow, underflow, inexact}; a monitor pops on each output.
module tb_fmul_72bit_norm;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst_sync = 1'b0;
  logic         req = 1'b0;
  logic         busy_out;
  logic         sign = 1'b0;
  logic [12:0]  exp_in = '0;
  logic [119:0] fract = '0;
  logic [5:0]   cls = '0;
  logic         valid;
  logic         busy_in = 1'b0;
  logic [71:0]  result;
  logic         f_inv, f_ovf, f_unf, f_inx;

  int checks_total = 0;
  int checks_passed = 0;
  logic [75:0] exp_q[$];

  localparam logic [119:0] ONE      = 120'h1 << 118;
  localparam logic [119:0] GBIT     = 120'h1 << 57;
  localparam logic [119:0] MLSB     = 120'h1 << 58;
  localparam logic [119:0] MONES    = {2'b00, 60'hFFFFFFFFFFFFFFF, 58'b0};
  localparam logic [59:0]  QNAN     = 60'h800000000000000;

  fmul_72bit_norm dut (
    .iCLOCK                (clk),
    .iRESET                (rst),
    .iRESET_SYNC           (rst_sync),
    .iDATA_REQ             (req),
    .oDATA_BUSY            (busy_out),
    .iDATA_SIGN            (sign),
    .iDATA_EXP             (exp_in),
    .iDATA_FRACT           (fract),
    .iDATA_EXCEPT_EXP_A0   (cls[5]),
    .iDATA_EXCEPT_EXP_B0   (cls[4]),
    .iDATA_EXCEPT_EXP_A1   (cls[3]),
    .iDATA_EXCEPT_EXP_B1   (cls[2]),
    .iDATA_EXCEPT_FRACT_A0 (cls[1]),
    .iDATA_EXCEPT_FRACT_B0 (cls[0]),
    .oDATA_VALID           (valid),
    .iDATA_BUSY            (busy_in),
    .oDATA_RESULT          (result),
    .oDATA_FLAG_INVALID    (f_inv),
    .oDATA_FLAG_OVERFLOW   (f_ovf),
    .oDATA_FLAG_UNDERFLOW  (f_unf),
    .oDATA_FLAG_INEXACT    (f_inx)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [75:0] actual, input logic [75:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor side: one output consumed per edge where valid is high and not stalled.
  task automatic checkOutput();
    logic [75:0] expected;
    if (exp_q.size() == 0) begin
      checks_total++;
      $display("[TB] FAIL unexpected_output: got %h, expected no output", {result, f_inv, f_ovf, f_unf, f_inx});
    end else begin
      expected = exp_q.pop_front();
      checkValue("result_flags", {result, f_inv, f_ovf, f_unf, f_inx}, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid && !busy_in) checkOutput();
  end

  // Called just after a rising edge; returns one time unit after the accepting edge.
  task automatic applyStimulus(input logic s, input logic [12:0] e, input logic [119:0] f,
                               input logic [5:0] c, input logic [71:0] res, input logic [3:0] flg,
                               input bit push);
    bit accepted;
    int waited;
    sign = s; exp_in = e; fract = f; cls = c; req = 1'b1;
    accepted = 1'b0;
    waited = 0;
    while (!accepted && waited < 100) begin
      @(posedge clk);
      accepted = !busy_out;
      waited++;
    end
    if (!accepted) begin
      checks_total++;
      $display("[TB] FAIL accept_timeout: got busy for %0d cycles, expected acceptance", waited);
    end else if (push) begin
      exp_q.push_back({res, flg});
    end
    #1 req = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    checkValue("drain", 76'(exp_q.size()), 76'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkValue("reset_state", {valid, result, f_inv, f_ovf, f_unf, f_inx}, 76'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(0, 13'h3FF, ONE,      6'b0, {1'b0, 11'h3FF, 60'h0}, 4'b0000, 1);
    applyStimulus(0, 13'h3FF, 120'h9 << 116, 6'b0, {1'b0, 11'h400, 60'h200000000000000}, 4'b0000, 1);
    applyStimulus(0, 13'h3FF, ONE | MLSB | GBIT, 6'b0, {1'b0, 11'h3FF, 60'h2}, 4'b0001, 1);
    applyStimulus(0, 13'h3FF, ONE | MONES | GBIT, 6'b0, {1'b0, 11'h400, 60'h0}, 4'b0001, 1);
    applyStimulus(0, 13'h3FF, ONE | (120'h1 << 59) | GBIT, 6'b0, {1'b0, 11'h3FF, 60'h2}, 4'b0001, 1);
    applyStimulus(1, 13'h3FF, ONE | GBIT | 120'h1, 6'b0, {1'b1, 11'h3FF, 60'h1}, 4'b0001, 1);
    applyStimulus(1, 13'h07FF, ONE, 6'b0, {1'b1, 11'h7FF, 60'h0}, 4'b0101, 1);
    applyStimulus(1, 13'h1FFF, ONE, 6'b0, {1'b1, 11'h000, 60'h0}, 4'b0011, 1);
    applyStimulus(0, 13'h07FE, ONE, 6'b0, {1'b0, 11'h7FE, 60'h0}, 4'b0000, 1);
    applyStimulus(0, 13'h07FE, ONE | MONES | GBIT, 6'b0, {1'b0, 11'h7FF, 60'h0}, 4'b0101, 1);
    applyStimulus(0, 13'h0001, ONE, 6'b0, {1'b0, 11'h001, 60'h0}, 4'b0000, 1);
    applyStimulus(0, 13'h0000, ONE, 6'b0, {1'b0, 11'h000, 60'h0}, 4'b0011, 1);
    applyStimulus(1, 13'h3FF, ONE, 6'b011010, {1'b0, 11'h7FF, QNAN}, 4'b1000, 1);
    applyStimulus(0, 13'h3FF, ONE, 6'b001000, {1'b0, 11'h7FF, QNAN}, 4'b1000, 1);
    applyStimulus(1, 13'h3FF, ONE, 6'b001010, {1'b1, 11'h7FF, 60'h0}, 4'b0000, 1);
    applyStimulus(1, 13'h07FF, ONE | GBIT, 6'b010000, {1'b1, 11'h000, 60'h0}, 4'b0000, 1);
    waitDrain();

    fork
      for (int i = 0; i < 6; i++)
        applyStimulus(0, 13'h3F0 + 13'(i), ONE, 6'b0, {1'b0, 11'h3F0 + 11'(i), 60'h0}, 4'b0000, 1);
      begin
        repeat (3) @(posedge clk);
        #1 busy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 busy_in = 1'b0;
      end
    join
    waitDrain();

    applyStimulus(0, 13'h3FF, ONE, 6'b0, {1'b0, 11'h3FF, 60'h0}, 4'b0000, 0);
    applyStimulus(0, 13'h400, ONE, 6'b0, {1'b0, 11'h400, 60'h0}, 4'b0000, 0);
    rst = 1'b1;
    @(negedge clk);
    checkValue("async_reset_valid", 76'(valid), 76'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    applyStimulus(0, 13'h3FF, ONE, 6'b0, {1'b0, 11'h3FF, 60'h0}, 4'b0000, 0);
    rst_sync = 1'b1;
    @(posedge clk);
    #1 rst_sync = 1'b0;
    @(negedge clk);
    checkValue("sync_reset_valid", 76'(valid), 76'd0);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
